// File: rtl/instruction_memory_blk.sv
// Block-fetch instruction memory with a fixed, parameterised access latency.
// A word-wide programming port preloads the array; the array itself is never reset.
module instruction_memory_blk #(
    parameter int ADDR_WIDTH      = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 5
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            READ,
    input  logic [ADDR_WIDTH-1:0]           ADDRESS,
    output logic [32*WORDS_PER_BLOCK-1:0]   READDATA,
    output logic                            BUSYWAIT,
    input  logic                            PROG_WRITE,
    input  logic [ADDR_WIDTH-3:0]           PROG_ADDR,
    input  logic [31:0]                     PROG_DATA
);

    localparam int OFFSET_BITS   = $clog2(WORDS_PER_BLOCK * 4);
    localparam int WORD_SEL_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_W         = ADDR_WIDTH - OFFSET_BITS;
    localparam int WIDX_W        = ADDR_WIDTH - 2;
    localparam int NUM_WORDS     = 1 << WIDX_W;
    localparam int CNT_W         = $clog2(LATENCY + 1);
    localparam int DATA_W        = 32 * WORDS_PER_BLOCK;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [31:0]         mem_q [NUM_WORDS];

    logic [BLK_W-1:0]    reqBlk;
    logic [BLK_W-1:0]    readBlk;
    logic [WIDX_W-1:0]   baseIdx;
    logic [DATA_W-1:0]   fetchData;
    logic                unusedAddrBits;

    assign reqBlk         = ADDRESS[ADDR_WIDTH-1:OFFSET_BITS];
    assign unusedAddrBits = ^ADDRESS[OFFSET_BITS-1:0];

    // No reset on the array so a loaded program survives a CPU reset.
    always_ff @(posedge CLK) begin
        if (PROG_WRITE) begin
            mem_q[PROG_ADDR] <= PROG_DATA;
        end
    end

    // In IDLE the live address feeds the read path so a single-cycle fetch can complete.
    always_comb begin
        readBlk   = (state_q == IDLE) ? reqBlk : blk_q;
        baseIdx   = WIDX_W'(readBlk) << WORD_SEL_BITS;
        fetchData = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            fetchData[32*i +: 32] = mem_q[baseIdx + WIDX_W'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (READ) begin
                    blk_d = reqBlk;
                    cnt_d = CNT_LOAD;
                    if (LATENCY == 1) begin
                        rdata_d = fetchData;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!READ) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        rdata_d = fetchData;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            rdata_q <= rdata_d;
        end
    end

    assign READDATA = rdata_q;
    assign BUSYWAIT = ((state_q == IDLE) && READ) || (state_q == BUSY);

endmodule

// File: tb/tb_instruction_memory_blk.sv
// Bench for instruction_memory_blk: a default-parameter instance plus a
// LATENCY=1 / one-word-block instance, both checked against array models.
module tb_instruction_memory_blk;

    localparam int TB_LAT = 5;

    logic         clk = 1'b0;
    logic         resetN;
    logic         read;
    logic [9:0]   address;
    logic [127:0] readData;
    logic         busyWait;
    logic         progWrite;
    logic [7:0]   progAddr;
    logic [31:0]  progData;

    logic         read1;
    logic [9:0]   address1;
    logic [31:0]  readData1;
    logic         busyWait1;
    logic         progWrite1;
    logic [7:0]   progAddr1;
    logic [31:0]  progData1;

    logic [31:0]  refMem  [256];
    logic [31:0]  refMem1 [256];
    logic [31:0]  preload [4] = '{32'h00000003, 32'h00010005, 32'h02020100, 32'h11000001};

    int checks   = 0;
    int failures = 0;

    instruction_memory_blk #(
        .ADDR_WIDTH(10), .WORDS_PER_BLOCK(4), .LATENCY(TB_LAT)
    ) dut (
        .CLK(clk), .RESET(resetN), .READ(read), .ADDRESS(address),
        .READDATA(readData), .BUSYWAIT(busyWait), .PROG_WRITE(progWrite),
        .PROG_ADDR(progAddr), .PROG_DATA(progData)
    );

    instruction_memory_blk #(
        .ADDR_WIDTH(10), .WORDS_PER_BLOCK(1), .LATENCY(1)
    ) dut1 (
        .CLK(clk), .RESET(resetN), .READ(read1), .ADDRESS(address1),
        .READDATA(readData1), .BUSYWAIT(busyWait1), .PROG_WRITE(progWrite1),
        .PROG_ADDR(progAddr1), .PROG_DATA(progData1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // A block is 16 bytes: four consecutive words starting at (addr/16)*4.
    function automatic logic [127:0] expBlock(input int addr);
        logic [127:0] r;
        int blk;
        blk = addr / 16;
        for (int i = 0; i < 4; i++) begin
            r[32*i +: 32] = refMem[blk*4 + i];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [9:0] addr);
        read    = rd;
        address = addr;
    endtask

    task automatic fetchBlock(input string tag, input logic [9:0] addr, input logic [9:0] midAddr);
        logic [127:0] expected;
        expected = expBlock(int'(addr));
        applyStimulus(1'b1, addr);
        #1 checkOutput($sformatf("%s_bw_req", tag), 128'(busyWait), 128'(1));
        for (int e = 1; e <= TB_LAT; e++) begin
            @(negedge clk);
            if (e == 2) address = midAddr;
            if (e < TB_LAT) checkOutput($sformatf("%s_bw_e%0d", tag, e), 128'(busyWait), 128'(1));
        end
        checkOutput($sformatf("%s_data", tag), readData, expected);
        checkOutput($sformatf("%s_bw_done", tag), 128'(busyWait), 128'(0));
        applyStimulus(1'b0, address);
        @(negedge clk);
        checkOutput($sformatf("%s_hold", tag), readData, expected);
    endtask

    // Write lands on edge landEdge of the fetch; only writes before the final edge are visible.
    task automatic fetchWithWrite(input string tag, input logic [9:0] addr, input int landEdge,
                                  input int waddr, input logic [31:0] wdata);
        logic [127:0] expected;
        if (landEdge < TB_LAT) begin
            refMem[waddr] = wdata;
            expected = expBlock(int'(addr));
        end else begin
            expected = expBlock(int'(addr));
            refMem[waddr] = wdata;
        end
        applyStimulus(1'b1, addr);
        if (landEdge == 1) begin
            progWrite = 1'b1; progAddr = 8'(waddr); progData = wdata;
        end
        for (int e = 1; e <= TB_LAT; e++) begin
            @(negedge clk);
            progWrite = 1'b0;
            if (e + 1 == landEdge) begin
                progWrite = 1'b1; progAddr = 8'(waddr); progData = wdata;
            end
        end
        checkOutput($sformatf("%s_data", tag), readData, expected);
        checkOutput($sformatf("%s_bw", tag), 128'(busyWait), 128'(0));
        applyStimulus(1'b0, address);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] prevData;
        logic [31:0]  word;
        logic [9:0]   a;
        logic [9:0]   b;
        int           land;

        resetN = 1'b0; read = 1'b0; address = '0; progWrite = 1'b0; progAddr = '0; progData = '0;
        read1 = 1'b0; address1 = '0; progWrite1 = 1'b0; progAddr1 = '0; progData1 = '0;
        #2 resetN = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            word = (i < 4) ? preload[i] : $urandom;
            refMem[i] = word;
            progWrite = 1'b1; progAddr = 8'(i); progData = word;
            word = $urandom;
            refMem1[i] = word;
            progWrite1 = 1'b1; progAddr1 = 8'(i); progData1 = word;
            @(negedge clk);
        end
        progWrite = 1'b0; progWrite1 = 1'b0;

        resetN = 1'b0;
        #1;
        checkOutput("reset_data", readData, 128'(0));
        checkOutput("reset_bw", 128'(busyWait), 128'(0));
        checkOutput("reset_data1", 128'(readData1), 128'(0));
        @(negedge clk);
        resetN = 1'b1;

        $display("[TB] latency fetch of block 0");
        applyStimulus(1'b1, 10'h000);
        #1 checkOutput("t1_bw_req", 128'(busyWait), 128'(1));
        for (int e = 1; e <= TB_LAT; e++) begin
            @(negedge clk);
            if (e < TB_LAT) checkOutput($sformatf("t1_bw_e%0d", e), 128'(busyWait), 128'(1));
        end
        checkOutput("t1_data", readData, 128'h11000001_02020100_00010005_00000003);
        checkOutput("t1_bw_done", 128'(busyWait), 128'(0));
        @(negedge clk);
        checkOutput("t1_bw_gap", 128'(busyWait), 128'(1));
        applyStimulus(1'b0, 10'h000);
        #1 checkOutput("t1_bw_idle", 128'(busyWait), 128'(0));
        @(negedge clk);
        checkOutput("t1_hold", readData, 128'h11000001_02020100_00010005_00000003);

        $display("[TB] alignment and mid-fetch address change");
        fetchBlock("t2_align", 10'h01C, 10'h000);
        prevData = expBlock(16);

        $display("[TB] abort after two edges");
        applyStimulus(1'b1, 10'h020);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 10'h020);
        #1 checkOutput("t3_bw_busy", 128'(busyWait), 128'(1));
        @(negedge clk);
        checkOutput("t3_bw_idle", 128'(busyWait), 128'(0));
        checkOutput("t3_data", readData, prevData);
        repeat (TB_LAT) @(negedge clk);
        checkOutput("t3_no_delivery", readData, prevData);

        $display("[TB] write on completion edge");
        fetchWithWrite("t4_race", 10'h000, TB_LAT, 2, 32'hDEADBEEF);
        checkOutput("t4_word2_old", 128'(readData[95:64]), 128'(32'h02020100));
        fetchBlock("t4_refetch", 10'h000, 10'h000);
        checkOutput("t4_word2_new", 128'(readData[95:64]), 128'(32'hDEADBEEF));

        for (int k = 0; k < 4; k++) begin
            a    = 10'($urandom_range(0, 1023));
            land = int'($urandom_range(1, TB_LAT));
            fetchWithWrite($sformatf("t4_rnd%0d", k), a, land,
                           int'(a / 16) * 4 + int'($urandom_range(0, 3)), $urandom);
        end

        for (int k = 0; k < 5; k++) begin
            a = 10'($urandom_range(0, 1023));
            b = 10'($urandom_range(0, 1023));
            fetchBlock($sformatf("rnd%0d", k), a, b);
        end

        $display("[TB] reset during a fetch");
        applyStimulus(1'b1, 10'h000);
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        read   = 1'b0;
        #1;
        checkOutput("t5_bw", 128'(busyWait), 128'(0));
        checkOutput("t5_data", readData, 128'(0));
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        fetchBlock("t5_after", 10'h000, 10'h000);

        $display("[TB] single-edge, single-word instance");
        for (int k = 0; k < 3; k++) begin
            a = 10'($urandom_range(0, 1023));
            b = 10'($urandom_range(0, 1023));
            read1 = 1'b1; address1 = a;
            #1 checkOutput($sformatf("t6_bw_req%0d", k), 128'(busyWait1), 128'(1));
            @(negedge clk);
            checkOutput($sformatf("t6_data_a%0d", k), 128'(readData1), 128'(refMem1[a / 4]));
            checkOutput($sformatf("t6_bw_done%0d", k), 128'(busyWait1), 128'(0));
            address1 = b;
            @(negedge clk);
            checkOutput($sformatf("t6_bw_gap%0d", k), 128'(busyWait1), 128'(1));
            checkOutput($sformatf("t6_gap_hold%0d", k), 128'(readData1), 128'(refMem1[a / 4]));
            @(negedge clk);
            checkOutput($sformatf("t6_data_b%0d", k), 128'(readData1), 128'(refMem1[b / 4]));
            checkOutput($sformatf("t6_bw_done_b%0d", k), 128'(busyWait1), 128'(0));
            read1 = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("t6_bw_idle%0d", k), 128'(busyWait1), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
